alu_ctrl_seq: RTL

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_pkg.sv | 53 +++++
 rtl/reg_onehot_dec.sv | 19 +
 rtl/alu_ctrl_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants, opcode encodings and sequencer state encoding for alu_ctrl_seq.
// ALU_CTRL_SEQ_MULDIV_EN adds the MUL/DIV opcodes and the extra T6 state.
package alu_ctrl_pkg;

    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_IDX_W = 4;

    // Field offsets measured down from the instruction MSB
    localparam int unsigned RA_OFS    = OPC_W;
    localparam int unsigned RB_OFS    = OPC_W + REG_IDX_W;
    localparam int unsigned RC_OFS    = OPC_W + 2 * REG_IDX_W;
    localparam int unsigned FIELDS_W  = OPC_W + 3 * REG_IDX_W;

    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SHR = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHL = 5'b00101;
    localparam logic [OPC_W-1:0] OP_ROR = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROL = 5'b00111;
    localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_ILL
`ifdef ALU_CTRL_SEQ_MULDIV_EN
        ,
        ST_T6
`endif
    } state_e;

    function automatic logic is_muldiv(input logic [OPC_W-1:0] opc);
        return (opc == OP_MUL) || (opc == OP_DIV);
    endfunction

    function automatic logic is_legal_op(input logic [OPC_W-1:0] opc);
        logic legal;
        legal = (opc[OPC_W-1:3] == 2'b00);
`ifdef ALU_CTRL_SEQ_MULDIV_EN
        legal = legal || is_muldiv(opc);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot enable decoder; all zero when disabled or index out of range.
module reg_onehot_dec
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Moore control sequencer driving datapath strobes for a fetch / 3-operand ALU instruction.
// Define ALU_CTRL_SEQ_MULDIV_EN to enable MUL/DIV with the two-cycle LO/HI writeback (T5/T6).
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    input  logic                MemReady,
    input  logic [INSTR_W-1:0]  IR,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic                LOin,
    output logic                HIin,
    output logic                Busy,
    output logic                Done,
    output logic                IllegalOp,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OPC_W-1:0]    AluOp
);

    state_e state_q, state_d;
    logic   t1_wait_q, t1_wait_d;

    logic [OPC_W-1:0]     opc_c;
    logic [REG_IDX_W-1:0] ra_c, rb_c, rc_c;
    logic [REG_IDX_W-1:0] rout_idx_c;
    logic                 rout_en_c, rin_en_c;
    logic                 legal_c, muldiv_c;

    assign opc_c = IR[INSTR_W-1 -: OPC_W];
    assign ra_c  = IR[INSTR_W-1-RA_OFS -: REG_IDX_W];
    assign rb_c  = IR[INSTR_W-1-RB_OFS -: REG_IDX_W];
    assign rc_c  = IR[INSTR_W-1-RC_OFS -: REG_IDX_W];

    generate
        if (INSTR_W > FIELDS_W) begin : g_spare
            logic unused_ir_c;
            assign unused_ir_c = ^IR[INSTR_W-FIELDS_W-1:0];
        end
    endgenerate

`ifdef ALU_CTRL_SEQ_MULDIV_EN
    assign muldiv_c = is_muldiv(opc_c);
`else
    assign muldiv_c = 1'b0;
`endif

    // Opcode and every register index must be valid before operand steps begin
    assign legal_c = is_legal_op(opc_c)
                  && (32'(ra_c) < NUM_REGS)
                  && (32'(rb_c) < NUM_REGS)
                  && (32'(rc_c) < NUM_REGS);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d    = state_q;
        t1_wait_d  = 1'b0;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Done       = 1'b0;
        IllegalOp  = 1'b0;
        AluOp      = '0;
        rout_en_c  = 1'b0;
        rout_idx_c = rb_c;
        rin_en_c   = 1'b0;
        Busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (Run) state_d = ST_T0;
            end
            ST_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // PC load only once even while memory stalls
                PCin    = !t1_wait_q;
                if (MemReady) begin
                    state_d = ST_T2;
                end else begin
                    t1_wait_d = 1'b1;
                end
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = legal_c ? ST_T3 : ST_ILL;
            end
            ST_T3: begin
                rout_en_c  = 1'b1;
                rout_idx_c = rb_c;
                Yin        = 1'b1;
                state_d    = ST_T4;
            end
            ST_T4: begin
                rout_en_c  = 1'b1;
                rout_idx_c = rc_c;
                Zin        = 1'b1;
                AluOp      = opc_c;
                state_d    = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
                if (muldiv_c) begin
                    LOin    = 1'b1;
                    state_d = ST_T6;
                end else begin
                    rin_en_c = 1'b1;
                    Done     = 1'b1;
                    state_d  = Run ? ST_T0 : ST_IDLE;
                end
`else
                rin_en_c = !muldiv_c;
                Done     = 1'b1;
                state_d  = Run ? ST_T0 : ST_IDLE;
`endif
            end
`ifdef ALU_CTRL_SEQ_MULDIV_EN
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
                state_d  = Run ? ST_T0 : ST_IDLE;
            end
`endif
            ST_ILL: begin
                IllegalOp = 1'b1;
                state_d   = Run ? ST_T0 : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    reg_onehot_dec #(
        .NUM_REGS (NUM_REGS)
    ) u_rin_dec (
        .idx    (ra_c),
        .en     (rin_en_c),
        .onehot (Rin)
    );

    reg_onehot_dec #(
        .NUM_REGS (NUM_REGS)
    ) u_rout_dec (
        .idx    (rout_idx_c),
        .en     (rout_en_c),
        .onehot (Rout)
    );

endmodule
